// File: rtl/shutdown_force_if.sv
// ---------------------------------------------------------------------------
// shutdown_force_if
//  Bundle of the shutdown-force request inputs and the external-latch write
//  outputs.
//  master : the latch writer (shutdown_force). It takes en/req/connected and
//           drives sel/data/le_n/busy/done/state.
//  slave  : the surrounding system. It drives the request side and observes
//           the latch side.
// ---------------------------------------------------------------------------
interface shutdown_force_if;
   logic       shutdown_force_en;
   logic [7:0] shutdown_force_req;
   logic [7:0] shutdown_force_connected;
   logic [2:0] shutdown_force_sel;
   logic       shutdown_force_data;
   logic       shutdown_force_le_n;
   logic       shutdown_force_busy;
   logic       shutdown_force_done;
   logic [7:0] shutdown_force_state;

   modport master (
      input  shutdown_force_en,
      input  shutdown_force_req,
      input  shutdown_force_connected,
      output shutdown_force_sel,
      output shutdown_force_data,
      output shutdown_force_le_n,
      output shutdown_force_busy,
      output shutdown_force_done,
      output shutdown_force_state
   );

   modport slave (
      output shutdown_force_en,
      output shutdown_force_req,
      output shutdown_force_connected,
      input  shutdown_force_sel,
      input  shutdown_force_data,
      input  shutdown_force_le_n,
      input  shutdown_force_busy,
      input  shutdown_force_done,
      input  shutdown_force_state
   );
endinterface

// File: rtl/shutdown_force.sv
// ---------------------------------------------------------------------------
// shutdown_force
//  Writes eight shutdown-force bits into an external 8-bit addressable latch
//  (3-bit address, one data pin, active-low latch enable). Each sweep visits
//  channels 0..7 with set-up / strobe / hold phases and commits every written
//  bit into a mirror of the latch contents.
//
// Ports
//  clk      in  system clock, rising edge
//  aresetn  in  synchronous active-low reset
//  bus      shutdown_force_if.master
//           en/req/connected in ; sel/data/le_n/busy/done/state out
//
// Configuration
//  SHUTDOWN_FORCE_REFRESH_EN : when defined the latch is rewritten
//  continuously (a new sweep starts even if target == mirror).
// ---------------------------------------------------------------------------
module shutdown_force #(
   parameter int SETUP_CYCLES  = 2,
   parameter int STROBE_CYCLES = 2,
   parameter int HOLD_CYCLES   = 2
) (
   input  logic              clk,
   input  logic              aresetn,
   shutdown_force_if.master  bus
);

   localparam int MAX_AB = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
   localparam int MAX_P  = (MAX_AB > HOLD_CYCLES) ? MAX_AB : HOLD_CYCLES;
   localparam int CW     = $clog2(MAX_P) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_DONE
   } fsm_t;

   fsm_t          r_fsm;
   fsm_t          w_fsm_next;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_ch;
   logic [7:0]    r_wr_val;
   logic [7:0]    r_state;
   logic          r_mirror_valid;

   logic [7:0]    w_target;
   logic          w_start_idle;
   logic          w_start_done;
   logic          w_phase_last;
   logic          w_in_phase;

   assign w_target = bus.shutdown_force_en ?
                     (bus.shutdown_force_req & bus.shutdown_force_connected) : 8'h00;

   // The DONE cycle makes the same start decision as IDLE would, with the
   // mirror treated as valid (it is fully updated by then). This keeps
   // back-to-back sweeps at exactly sweep length + 1 cycle apart.
`ifdef SHUTDOWN_FORCE_REFRESH_EN
   assign w_start_idle = 1'b1;
   assign w_start_done = 1'b1;
`else
   assign w_start_idle = !r_mirror_valid || (w_target != r_state);
   assign w_start_done = (w_target != r_state);
`endif

   assign w_in_phase = (r_fsm == S_SETUP) || (r_fsm == S_STROBE) || (r_fsm == S_HOLD);

   always_comb begin
      w_phase_last = 1'b0;
      case (r_fsm)
         S_SETUP:  w_phase_last = (r_cnt == CW'(SETUP_CYCLES - 1));
         S_STROBE: w_phase_last = (r_cnt == CW'(STROBE_CYCLES - 1));
         S_HOLD:   w_phase_last = (r_cnt == CW'(HOLD_CYCLES - 1));
         default:  w_phase_last = 1'b0;
      endcase
   end

   // State register plus sweep datapath
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         r_fsm          <= S_IDLE;
         r_cnt          <= '0;
         r_ch           <= 3'd0;
         r_wr_val       <= 8'h00;
         r_state        <= 8'h00;
         r_mirror_valid <= 1'b0;
      end else begin
         r_fsm <= w_fsm_next;
         r_cnt <= (w_in_phase && !w_phase_last) ? r_cnt + 1'b1 : '0;

         if (((r_fsm == S_IDLE) || (r_fsm == S_DONE)) && (w_fsm_next == S_SETUP)) begin
            r_wr_val <= w_target;
            r_ch     <= 3'd0;
         end

         if ((r_fsm == S_HOLD) && w_phase_last) begin
            r_state[r_ch] <= r_wr_val[r_ch];
            // ch==7 leaves for DONE, so the channel index never wraps.
            if (r_ch != 3'd7)
               r_ch <= r_ch + 3'd1;
         end

         if (r_fsm == S_DONE)
            r_mirror_valid <= 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      w_fsm_next = r_fsm;
      case (r_fsm)
         S_IDLE:   if (w_start_idle) w_fsm_next = S_SETUP;
         S_SETUP:  if (w_phase_last) w_fsm_next = S_STROBE;
         S_STROBE: if (w_phase_last) w_fsm_next = S_HOLD;
         S_HOLD:   if (w_phase_last) w_fsm_next = (r_ch == 3'd7) ? S_DONE : S_SETUP;
         S_DONE:   w_fsm_next = w_start_done ? S_SETUP : S_IDLE;
         default:  w_fsm_next = S_IDLE;
      endcase
   end

   // Outputs: sel/data come from registers that only change at a HOLD->SETUP
   // or sweep-start boundary, so they are stable around every strobe.
   always_comb begin
      bus.shutdown_force_sel   = r_ch;
      bus.shutdown_force_data  = r_wr_val[r_ch];
      bus.shutdown_force_le_n  = (r_fsm != S_STROBE);
      bus.shutdown_force_busy  = w_in_phase;
      bus.shutdown_force_done  = (r_fsm == S_DONE);
      bus.shutdown_force_state = r_state;
   end

endmodule

// File: tb/tb_shutdown_force.sv
// ---------------------------------------------------------------------------
// tb_shutdown_force
//  Drives shutdown_force with directed and random request patterns and
//  compares every cycle against a sweep-level reference: a sweep is 48 busy
//  cycles (index 0..47, channel = idx/6, strobe at idx%6 in {2,3}) followed
//  by one DONE cycle. A model of the external latch is also kept and
//  compared to the snapshot at the end of each sweep.
// ---------------------------------------------------------------------------
module tb_shutdown_force;

   localparam int PH = 6;   // set-up + strobe + hold per channel
   localparam int SW = 48;  // busy cycles per sweep

   localparam int M_RST   = 0;
   localparam int M_IDLE  = 1;
   localparam int M_SWEEP = 2;
   localparam int M_DONE  = 3;

   logic clk = 1'b0;
   logic aresetn = 1'b0;
   always #5 clk = ~clk;

   shutdown_force_if bus_if ();

   shutdown_force dut (
      .clk     (clk),
      .aresetn (aresetn),
      .bus     (bus_if.master)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int         m_mode  = M_RST;
   int         m_i     = 0;
   logic       m_valid = 1'b0;
   logic [7:0] m_state = 8'h00;
   logic [7:0] m_snap  = 8'h00;
   logic [7:0] latch   = 8'h00;
   int         sweeps  = 0;

   always @(negedge clk) begin
      logic [7:0] tgt;
      logic [7:0] mask;
      logic [7:0] exp_state;
      logic       go;
      int         ch;
      int         off;

      case (m_mode)
         M_RST: begin
            check("rst_le_n",  bus_if.shutdown_force_le_n, 1);
            check("rst_busy",  bus_if.shutdown_force_busy, 0);
            check("rst_done",  bus_if.shutdown_force_done, 0);
            check("rst_sel",   bus_if.shutdown_force_sel, 0);
            check("rst_data",  bus_if.shutdown_force_data, 0);
            check("rst_state", bus_if.shutdown_force_state, 0);
         end
         M_IDLE: begin
            check("idle_le_n",  bus_if.shutdown_force_le_n, 1);
            check("idle_busy",  bus_if.shutdown_force_busy, 0);
            check("idle_done",  bus_if.shutdown_force_done, 0);
            check("idle_state", bus_if.shutdown_force_state, m_state);
         end
         M_SWEEP: begin
            ch  = m_i / PH;
            off = m_i % PH;
            mask = 8'((1 << ch) - 1);
            exp_state = (m_snap & mask) | (m_state & ~mask);
            check("sw_busy",  bus_if.shutdown_force_busy, 1);
            check("sw_done",  bus_if.shutdown_force_done, 0);
            check("sw_le_n",  bus_if.shutdown_force_le_n, (off == 2 || off == 3) ? 0 : 1);
            check("sw_sel",   bus_if.shutdown_force_sel, ch);
            check("sw_data",  bus_if.shutdown_force_data, m_snap[ch]);
            check("sw_state", bus_if.shutdown_force_state, exp_state);
         end
         default: begin
            check("dn_busy",  bus_if.shutdown_force_busy, 0);
            check("dn_done",  bus_if.shutdown_force_done, 1);
            check("dn_le_n",  bus_if.shutdown_force_le_n, 1);
            check("dn_state", bus_if.shutdown_force_state, m_snap);
            check("dn_latch", latch, m_snap);
            sweeps++;
            $display("sweep %0d complete: value=%02h t=%0t", sweeps, m_snap, $time);
         end
      endcase

      // External latch is transparent while le_n is low.
      if (bus_if.shutdown_force_le_n === 1'b0)
         latch[bus_if.shutdown_force_sel] = bus_if.shutdown_force_data;

      // Decide what the next edge should produce, from the inputs it samples.
      tgt = bus_if.shutdown_force_en ?
            (bus_if.shutdown_force_req & bus_if.shutdown_force_connected) : 8'h00;
      if (!aresetn) begin
         m_mode  = M_RST;
         m_valid = 1'b0;
         m_state = 8'h00;
      end else begin
         go = 1'b0;
         if (m_mode == M_SWEEP) begin
            if (m_i == SW - 1) m_mode = M_DONE;
            else m_i++;
         end else begin
            if (m_mode == M_DONE) begin
               m_valid = 1'b1;
               m_state = m_snap;
            end
`ifdef SHUTDOWN_FORCE_REFRESH_EN
            go = 1'b1;
`else
            go = !m_valid || (tgt != m_state);
`endif
            if (go) begin
               m_mode = M_SWEEP;
               m_i    = 0;
               m_snap = tgt;
            end else begin
               m_mode = M_IDLE;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic set_in(input logic en, input logic [7:0] req, input logic [7:0] conn);
      bus_if.shutdown_force_en        = en;
      bus_if.shutdown_force_req       = req;
      bus_if.shutdown_force_connected = conn;
   endtask

   // Bounded wait for the writer to reach a channel (optionally in strobe).
   task automatic wait_ch(input string tag, input logic [2:0] ch, input logic strobe);
      int n;
      n = 0;
      while (n < 200 && !(bus_if.shutdown_force_busy === 1'b1 &&
                          bus_if.shutdown_force_sel === ch &&
                          (!strobe || bus_if.shutdown_force_le_n === 1'b0))) begin
         step(1);
         n++;
      end
      check(tag, (n < 200) ? 1 : 0, 1);
   endtask

   initial begin
      set_in(1'b1, 8'h00, 8'hFF);
      aresetn = 1'b0;
      step(3);
      aresetn = 1'b1;
      step(260);                        // initial sweep of zeros, then quiet

      set_in(1'b1, 8'hA5, 8'hFF);       // one sweep to A5
      step(60);
      set_in(1'b1, 8'hFF, 8'h0F);       // connected mask applied
      step(60);

      set_in(1'b1, 8'h01, 8'hFF);       // change mid-sweep -> second sweep
      wait_ch("wait_ch3", 3'd3, 1'b0);
      set_in(1'b1, 8'h03, 8'hFF);
      step(120);

      set_in(1'b1, 8'hFF, 8'hFF);       // en drop and restore
      step(60);
      set_in(1'b0, 8'hFF, 8'hFF);
      step(60);
      set_in(1'b1, 8'hFF, 8'hFF);
      step(60);

      set_in(1'b1, 8'h5A, 8'hFF);       // reset during ch4 strobe
      wait_ch("wait_ch4", 3'd4, 1'b1);
      aresetn = 1'b0;
      step(1);
      aresetn = 1'b1;
      step(120);

      for (int k = 0; k < 40; k++) begin
         set_in($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom));
         if ($urandom_range(0, 15) == 0) begin
            aresetn = 1'b0;
            step($urandom_range(1, 3));
            aresetn = 1'b1;
         end
         step($urandom_range(1, 70));
      end
      step(120);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
